// File: rtl/alu_pkg.sv
// Shared opcode encodings and status-flag bit positions for the ALU.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_SUB        = 2'b00,
      OP_NAND       = 2'b01,
      OP_START_ONES = 2'b10,
      OP_DECODE     = 2'b11
   } op_e;

   localparam int FLAG_ERR      = 0;
   localparam int FLAG_NEG      = 1;
   localparam int FLAG_POS      = 2;
   localparam int FLAG_OVERFLOW = 3;
   localparam int FLAG_W        = 4;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result and status flags for one operation.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LEN   = 2
) (
   input  logic [WIDTH-1:0]  arg0,
   input  logic [WIDTH-1:0]  arg1,
   input  logic [LEN-1:0]    oper,
   output logic [WIDTH-1:0]  result,
   output logic [FLAG_W-1:0] flag
);

   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] ones_run;
   logic [WIDTH-1:0] ones_cnt;
   logic [WIDTH-1:0] dec_idx;
   logic             one_hot;
   logic             oper_hi;
   logic             err;
   logic             ovf;

   assign diff    = arg0 - arg1;
   assign one_hot = (arg0 != '0) && ((arg0 & (arg0 - WIDTH'(1))) == '0);
   // Opcodes above the two base bits are unsupported whenever LEN > 2.
   assign oper_hi = (oper >> 2) != '0;

   // ones_run[gi] is set while every bit from the MSB down to gi is a one.
   assign ones_run[WIDTH-1] = arg0[WIDTH-1];
   generate
      for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_run
         assign ones_run[gi] = ones_run[gi+1] & arg0[gi];
      end
   endgenerate

   always_comb begin
      ones_cnt = '0;
      dec_idx  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones_cnt = ones_cnt + {{(WIDTH-1){1'b0}}, ones_run[i]};
         if (arg0[i]) begin
            dec_idx = dec_idx | WIDTH'(i);
         end
      end
   end

   always_comb begin
      result = '0;
      err    = 1'b0;
      ovf    = 1'b0;
      if (oper_hi) begin
         err = 1'b1;
      end else begin
         case (op_e'(oper[1:0]))
            OP_SUB: begin
               result = diff;
               ovf    = (arg0[WIDTH-1] != arg1[WIDTH-1]) &&
                        (diff[WIDTH-1] != arg0[WIDTH-1]);
            end
            OP_NAND:       result = ~(arg0 & arg1);
            OP_START_ONES: result = ones_cnt;
            OP_DECODE: begin
               if (one_hot) result = dec_idx;
               else         err    = 1'b1;
            end
            default:       err = 1'b1;
         endcase
      end
   end

   always_comb begin
      flag                = '0;
      flag[FLAG_ERR]      = err;
      flag[FLAG_NEG]      = result[WIDTH-1];
      flag[FLAG_POS]      = (result != '0) && !result[WIDTH-1];
      flag[FLAG_OVERFLOW] = ovf;
   end

endmodule

// File: rtl/alu_top.sv
// ALU top level: registers the combinational core outputs, one-cycle latency.
module alu_top
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LEN   = 2
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [WIDTH-1:0] i_arg0,
   input  logic [WIDTH-1:0] i_arg1,
   input  logic [LEN-1:0]   i_oper,
   output logic [WIDTH-1:0] o_result,
   output logic [3:0]       o_flag
);

   logic [WIDTH-1:0]  result_next;
   logic [FLAG_W-1:0] flag_next;
   logic [WIDTH-1:0]  result_reg;
   logic [FLAG_W-1:0] flag_reg;

   alu_core #(
      .WIDTH (WIDTH),
      .LEN   (LEN)
   ) u_core (
      .arg0   (i_arg0),
      .arg1   (i_arg1),
      .oper   (i_oper),
      .result (result_next),
      .flag   (flag_next)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         result_reg <= '0;
         flag_reg   <= '0;
      end else begin
         result_reg <= result_next;
         flag_reg   <= flag_next;
      end
   end

   assign o_result = result_reg;
   assign o_flag   = flag_reg;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed vectors, reset behaviour, random vs. model.
module tb_alu_top;

   localparam int W = 4;
   localparam int L = 2;

   logic          i_clk;
   logic          i_rstn;
   logic [W-1:0]  i_arg0;
   logic [W-1:0]  i_arg1;
   logic [L-1:0]  i_oper;
   logic [W-1:0]  o_result;
   logic [3:0]    o_flag;

   int err_cnt;
   int chk_cnt;

   alu_top #(.WIDTH(W), .LEN(L)) dut (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_arg0   (i_arg0),
      .i_arg1   (i_arg1),
      .i_oper   (i_oper),
      .o_result (o_result),
      .o_flag   (o_flag)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Reference model built from the arithmetic meaning of each operation.
   task automatic model(input int a, input int b, input int op,
                        output int res, output logic [3:0] flg);
      int sa, sb, sd, n;
      int half, full;
      half = 1 << (W - 1);
      full = 1 << W;
      res  = 0;
      flg  = 4'b0000;
      case (op)
         0: begin
            sa  = (a >= half) ? a - full : a;
            sb  = (b >= half) ? b - full : b;
            sd  = sa - sb;
            res = (a - b + full) % full;
            if (sd < -half || sd > half - 1) flg[3] = 1'b1;
         end
         1: res = (full - 1) - (a & b);
         2: begin
            n = 0;
            while (n < W && a[W-1-n]) n++;
            res = n;
         end
         default: begin
            if ($countones(a) == 1) res = $clog2(a);
            else flg[0] = 1'b1;
         end
      endcase
      if (res >= half) flg[1] = 1'b1;
      else if (res != 0) flg[2] = 1'b1;
   endtask

   task automatic drive(input int a, input int b, input int op);
      @(negedge i_clk);
      i_arg0 = W'(a);
      i_arg1 = W'(b);
      i_oper = L'(op);
   endtask

   task automatic run_op(input string tag, input int a, input int b, input int op);
      int         res;
      logic [3:0] flg;
      drive(a, b, op);
      model(a, b, op, res, flg);
      @(posedge i_clk);
      #1;
      check({tag, ".res"}, 32'(o_result), 32'(res));
      check({tag, ".flg"}, 32'(o_flag), 32'(flg));
   endtask

   task automatic run_exact(input string tag, input int a, input int b, input int op,
                            input int res, input int flg);
      drive(a, b, op);
      @(posedge i_clk);
      #1;
      check({tag, ".res"}, 32'(o_result), 32'(res));
      check({tag, ".flg"}, 32'(o_flag), 32'(flg));
   endtask

   initial begin
      int         res;
      logic [3:0] flg;
      err_cnt = 0;
      chk_cnt = 0;
      i_rstn  = 1'b0;
      i_arg0  = '0;
      i_arg1  = '0;
      i_oper  = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset.res", 32'(o_result), 32'd0);
      check("reset.flg", 32'(o_flag), 32'd0);
      @(negedge i_clk);
      i_rstn = 1'b1;

      // Directed vectors with hand-derived expectations.
      run_exact("sub_pos",   4'b0101, 4'b0011, 0, 4'b0010, 4'b0100);
      run_exact("sub_ovf",   4'b0111, 4'b1000, 0, 4'b1111, 4'b1010);
      run_exact("nand",      4'b1111, 4'b0000, 1, 4'b1111, 4'b0010);
      run_exact("ones_1100", 4'b1100, 4'b1011, 2, 4'b0010, 4'b0100);
      run_exact("ones_0111", 4'b0111, 4'b1111, 2, 4'b0000, 4'b0000);
      run_exact("ones_1111", 4'b1111, 4'b0000, 2, 4'b0100, 4'b0100);
      run_exact("dec_0010",  4'b0010, 4'b1111, 3, 4'b0001, 4'b0100);
      run_exact("dec_1010",  4'b1010, 4'b0000, 3, 4'b0000, 4'b0001);
      run_exact("dec_1000",  4'b1000, 4'b0000, 3, 4'b0011, 4'b0100);
      run_exact("dec_zero",  4'b0000, 4'b0000, 3, 4'b0000, 4'b0001);
      run_exact("sub_zero",  4'b0110, 4'b0110, 0, 4'b0000, 4'b0000);
      run_exact("sub_novf",  4'b1000, 4'b0001, 0, 4'b0111, 4'b1100);

      // Asynchronous reset mid-phase with nonzero outputs, no clock edge involved.
      run_exact("pre_rst", 4'b1111, 4'b0000, 1, 4'b1111, 4'b0010);
      #2;
      i_rstn = 1'b0;
      #1;
      check("async_rst.res", 32'(o_result), 32'd0);
      check("async_rst.flg", 32'(o_flag), 32'd0);
      i_arg0 = 4'b0101;
      i_arg1 = 4'b0011;
      i_oper = 2'b00;
      @(posedge i_clk);
      #1;
      check("held_rst.res", 32'(o_result), 32'd0);
      check("held_rst.flg", 32'(o_flag), 32'd0);
      @(negedge i_clk);
      i_rstn = 1'b1;
      i_arg0 = 4'b0111;
      i_arg1 = 4'b1000;
      i_oper = 2'b00;
      @(posedge i_clk);
      #1;
      check("post_rst.res", 32'(o_result), 32'b1111);
      check("post_rst.flg", 32'(o_flag), 32'b1010);

      // Random vectors against the reference model.
      for (int k = 0; k < 50; k++) begin
         int a, b, op;
         a  = int'($urandom_range(0, (1 << W) - 1));
         b  = int'($urandom_range(0, (1 << W) - 1));
         op = int'($urandom_range(0, 3));
         // Bias some decode cases towards one-hot operands so the valid path is hit.
         if (op == 3 && k % 2 == 0) a = 1 << $urandom_range(0, W - 1);
         run_op($sformatf("rnd%0d_op%0d_a%0h_b%0h", k, op, a, b), a, b, op);
      end

      // Back-to-back issue: each cycle's result follows the previous cycle's inputs.
      drive(4'b0011, 4'b0101, 0);
      model(4'b0011, 4'b0101, 0, res, flg);
      @(negedge i_clk);
      check("b2b0.res", 32'(o_result), 32'(res));
      check("b2b0.flg", 32'(o_flag), 32'(flg));
      i_arg0 = 4'b0100;
      i_oper = 2'b11;
      model(4'b0100, 0, 3, res, flg);
      @(negedge i_clk);
      check("b2b1.res", 32'(o_result), 32'(res));
      check("b2b1.flg", 32'(o_flag), 32'(flg));

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
